campbell_frame_rx: RTL

//  Host-side / loopback decoder for the 11-byte Campbell telemetry frame sent over the 4800-baud UART link.

---
 rtl/campbell_frame_rx.sv | 107 ++++++++++
 1 files changed

// File: rtl/campbell_frame_rx.sv
// Decoder for the 11-byte Campbell telemetry frame. It reassembles two 24-bit power words
// and two 16-bit pulse counts, and uses inter-byte silence to locate frame boundaries.
module campbell_frame_rx #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMR_W          = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [23:0] power1,
    output logic [23:0] power2,
    output logic [15:0] count1,
    output logic [15:0] count2,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {HUNT, IDLE, COLLECT} state_t;

    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [TMR_W-1:0] timer;
    logic [3:0]       idx;
    logic [9:0][7:0]  shadow;
    logic             tout;

    // A received byte always wins over a timeout in the same cycle.
    assign tout = !rx_valid && (timer == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (rx_valid) begin
            timer <= '0;
        end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= '0;
            shadow      <= '0;
            power1      <= '0;
            power2      <= '0;
            count1      <= '0;
            count2      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                HUNT: begin
                    if (tout) state <= IDLE;
                end
                IDLE: begin
                    if (rx_valid) begin
                        shadow[0] <= rx_data;
                        idx       <= 4'd1;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
                        if (idx == 4'd10) begin
                            idx <= '0;
                            if (rx_data == 8'hFF) begin
                                power1      <= {shadow[0], shadow[1], shadow[2]};
                                power2      <= {shadow[3], shadow[4], shadow[5]};
                                count1      <= {shadow[6], shadow[7]};
                                count2      <= {shadow[8], shadow[9]};
                                frame_valid <= 1'b1;
                                frame_cnt   <= frame_cnt + 1'b1;
                                state       <= IDLE;
                            end else begin
                                // A bad terminator means we may be misaligned: resync on silence.
                                frame_err <= 1'b1;
                                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
                                state     <= HUNT;
                            end
                        end else begin
                            shadow[idx] <= rx_data;
                            idx         <= idx + 1'b1;
                        end
                    end else if (tout) begin
                        // The gap itself is the boundary, so the next byte may start a frame.
                        frame_err <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
                        idx       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
